grey_frame_sequencer: RTL and testbench
=======================================

// Module: grey_frame_sequencer
// PURPOSE
//  Frame-level controller for the RGB-to-greyscale converter. On start it streams
//  num_pixels packed RGB pixels from a source pixel RAM through the external
//  combinational converter and writes each grey byte to a destination RAM at the same
//  address. Throughput is 1 pixel/clk. A destination ready signal applies backpressure.
// PARAMETERS
//  ADDR_W   14   address width of both RAMs (max 16384 pixels)
//  PIX_W    24   packed pixel width {R[23:16],G[15:8],B[7:0]}
// PORTS
//  clk          in   1        single clock; all logic on posedge
//  rst          in   1        synchronous reset, active-high
//  start        in   1        1-clk pulse; begins a frame when idle
//  abort        in   1        1-clk pulse; cancels the frame in progress
//  num_pixels   in   ADDR_W+1 frame length, sampled on an accepted start
//  busy         out  1        high from the first RUN cycle until the last write is accepted
//  done         out  1        1-clk pulse after the last write is accepted
//  aborted      out  1        1-clk pulse after an abort is taken
//  rd_en        out  1        source RAM read enable
//  rd_addr      out  ADDR_W   source RAM read address
//  rd_data      in   PIX_W    source RAM data; valid 1 clk after rd_en; RAM holds it while rd_en=0
//  conv_red     out  8        to converter, registered
//  conv_green   out  8        to converter, registered
//  conv_blue    out  8        to converter, registered
//  conv_grey    in   8        from converter (combinational from conv_*)
//  wr_en        out  1        destination RAM write request
//  wr_addr      out  ADDR_W   destination address
//  wr_data      out  8        = conv_grey
//  wr_ready     in   1        destination accepts the write this clk when wr_en & wr_ready
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, aborted, rd_en, wr_en = 0; rd_addr, wr_addr, conv_* = 0;
//    s1_v = s2_v = 0.
//  - FSM: IDLE -> RUN on start. RUN -> IDLE after the last write is accepted (done=1 next clk)
//    or on abort (aborted=1 next clk). start is ignored while in RUN.
//    start with num_pixels=0: no reads and no writes; done pulses 1 clk after start.
//  - Pipeline: P0 read issue -> P1 rd_data valid (s1_v) -> P2 conv_* registered
//    (s2_v = wr_en).
//    adv = !s2_v | wr_ready.
//    rd_en = RUN & adv & (issued < num_pixels); rd_addr increments after each issue.
//    On adv: conv_* <= rd_data fields; s2_v <= s1_v; wr_addr <= address of the s1 pixel;
//    s1_v <= rd_en.
//    On !adv: all pipeline state holds; rd_en=0; wr_en, wr_addr, wr_data stay stable.
//  - Latency (no stall): start at clk 0; rd_en at clk 1 (addr 0); pixel k written at clk 3+k;
//    last write at clk N+2; done at clk N+3; busy high clks 1..N+2.
//  - Completion: when the write of address num_pixels-1 is accepted. Addresses are strictly
//    ascending; each is written exactly once; no wrap beyond num_pixels-1.
//  - num_pixels > 2^ADDR_W is clamped to 2^ADDR_W.
//  - abort in RUN: in the next clk rd_en=0, s1_v=s2_v=0, wr_en=0, busy=0, aborted=1.
//    abort and start in the same clk: abort wins; no new frame starts. abort in IDLE: ignored.
//  - rst mid-frame: immediate return to the reset state; no done and no aborted pulse.
// TESTING
//  1. rst, start with num_pixels=4, wr_ready=1, RAM[0]=24'hC86432 -> rd_en clks 1-4;
//     clk 3: wr_en=1, wr_addr=0, conv_red/green/blue=C8/64/32, wr_data=model(C8,64,32);
//     done at clk 7.
//  2. num_pixels=8, wr_ready low for clks 4-6 -> wr_en/wr_addr=1 held stable;
//     no rd_en while stalled; all 8 addresses written once, in order; done 3 clks late.
//  3. num_pixels=0 -> no rd_en, no wr_en; done=1 at clk 1; busy never asserted.
//  4. num_pixels=16, abort at clk 6 -> clk 7: wr_en=0, busy=0, aborted=1;
//     a new start at clk 9 runs from address 0.
//  5. start pulsed again at clk 3 of a 10-pixel frame -> ignored; exactly 10 writes, 1 done.
//  6. rst at clk 5 mid-frame -> all outputs 0 the following clk; no done, no aborted;
//     num_pixels=16384 full frame -> last wr_addr=14'h3FFF, done at clk 16387.

Source files
------------

// File: rtl/grey_frame_sequencer.sv
// Frame sequencer for the RGB-to-grey converter: streams num_pixels source pixels through
// a 3-stage read/convert/write pipeline into the destination RAM at 1 pixel/clk with backpressure.
module grey_frame_sequencer #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned PIX_W  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   num_pixels,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [PIX_W-1:0]  rd_data,
   output logic [7:0]        conv_red,
   output logic [7:0]        conv_green,
   output logic [7:0]        conv_blue,
   input  logic [7:0]        conv_grey,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic              wr_ready
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] MAX_PIX = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic {IDLE, RUN} stateT;

   stateT             state, stateNext;
   logic [CNT_W-1:0]  numReg;
   logic [CNT_W-1:0]  issued;
   logic [CNT_W-1:0]  numClamped;
   logic [ADDR_W-1:0] s1Addr;
   logic [ADDR_W-1:0] lastAddr;
   logic              s1Valid;
   logic              s2Valid;
   logic              adv;
   logic              issue;
   logic              writeDone;
   logic              frameStart;
   logic              doneNext;
   logic              abortedNext;

   assign numClamped = (num_pixels > MAX_PIX) ? MAX_PIX : num_pixels;
   assign lastAddr   = ADDR_W'(numReg - CNT_W'(1));

   // Whole pipeline advances together unless a pending write is being held off
   assign adv       = !s2Valid || wr_ready;
   assign issue     = (state == RUN) && adv && (issued < numReg);
   assign writeDone = s2Valid && wr_ready && (wr_addr == lastAddr);

   assign busy    = (state == RUN);
   assign rd_en   = issue;
   assign rd_addr = issued[ADDR_W-1:0];
   assign wr_en   = s2Valid;
   assign wr_data = conv_grey;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // Abort takes priority over both a new start and a completing write
   always_comb begin
      stateNext   = state;
      doneNext    = 1'b0;
      abortedNext = 1'b0;
      frameStart  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               if (num_pixels == '0) begin
                  doneNext = 1'b1;
               end else begin
                  stateNext  = RUN;
                  frameStart = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               stateNext   = IDLE;
               abortedNext = 1'b1;
            end else if (writeDone) begin
               stateNext = IDLE;
               doneNext  = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done       <= 1'b0;
         aborted    <= 1'b0;
         numReg     <= '0;
         issued     <= '0;
         s1Valid    <= 1'b0;
         s1Addr     <= '0;
         s2Valid    <= 1'b0;
         wr_addr    <= '0;
         conv_red   <= '0;
         conv_green <= '0;
         conv_blue  <= '0;
      end else begin
         done    <= doneNext;
         aborted <= abortedNext;
         if (frameStart) begin
            numReg  <= numClamped;
            issued  <= '0;
            s1Valid <= 1'b0;
            s2Valid <= 1'b0;
         end else if (state == RUN) begin
            if (abort) begin
               s1Valid <= 1'b0;
               s2Valid <= 1'b0;
            end else if (adv) begin
               if (issue) issued <= issued + CNT_W'(1);
               s1Valid    <= issue;
               s1Addr     <= rd_addr;
               s2Valid    <= s1Valid;
               wr_addr    <= s1Addr;
               conv_red   <= rd_data[23:16];
               conv_green <= rd_data[15:8];
               conv_blue  <= rd_data[7:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_grey_frame_sequencer.sv
// Randomized self-checking bench for grey_frame_sequencer: source/destination RAM and
// converter models plus a frame-level reference (write order, counts, completion timing).
module tb_grey_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [14:0] num_pixels;
   logic        busy;
   logic        done;
   logic        aborted;
   logic        rd_en;
   logic [13:0] rd_addr;
   logic [23:0] rd_data;
   logic [7:0]  conv_red;
   logic [7:0]  conv_green;
   logic [7:0]  conv_blue;
   logic [7:0]  conv_grey;
   logic        wr_en;
   logic [13:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_ready;

   logic [23:0] src [0:16383];

   int nCompared   = 0;
   int nMismatched = 0;
   int cyc = 0;
   int t0  = 0;

   int doneCnt, abortCnt, rdCnt, wrCnt, busyCnt, stallCnt, doneCyc, expNext, lastWrAddr;
   bit prevStall;
   logic [13:0] heldAddr;

   grey_frame_sequencer #(.ADDR_W(14), .PIX_W(24)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .num_pixels(num_pixels),
      .busy(busy), .done(done), .aborted(aborted),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .conv_red(conv_red), .conv_green(conv_green), .conv_blue(conv_blue),
      .conv_grey(conv_grey),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] greyOf(input logic [23:0] p);
      int s;
      s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
      return 8'(s >> 8);
   endfunction

   // Source RAM: data one clock after rd_en, held otherwise
   always @(posedge clk) if (rd_en) rd_data <= src[rd_addr];

   assign conv_grey = greyOf({conv_red, conv_green, conv_blue});

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clearStats();
      doneCnt = 0; abortCnt = 0; rdCnt = 0; wrCnt = 0; busyCnt = 0;
      stallCnt = 0; doneCyc = -1; expNext = 0; lastWrAddr = -1; prevStall = 1'b0;
   endtask

   // Record frame-level events; check write order/data and stall stability as they happen
   task automatic observe();
      if (done) begin doneCnt++; doneCyc = cyc; end
      if (aborted) abortCnt++;
      if (rd_en) rdCnt++;
      if (busy) busyCnt++;
      if (prevStall) begin
         checkEq("hold_en", 32'(wr_en), 32'd1);
         checkEq("hold_addr", 32'(wr_addr), 32'(heldAddr));
      end
      if (wr_en && !wr_ready) begin
         stallCnt++;
         checkEq("stall_rd", 32'(rd_en), 32'd0);
         prevStall = 1'b1;
         heldAddr  = wr_addr;
      end else begin
         prevStall = 1'b0;
      end
      if (wr_en && wr_ready) begin
         checkEq("wr_addr", 32'(wr_addr), 32'(expNext));
         checkEq("wr_data", 32'(wr_data), 32'(greyOf(src[wr_addr])));
         lastWrAddr = int'(wr_addr);
         expNext++;
         wrCnt++;
      end
   endtask

   task automatic cycle(input logic st, input logic ab, input logic rdy, input logic rs);
      @(posedge clk);
      #1;
      cyc++;
      start = st; abort = ab; wr_ready = rdy; rst = rs;
      #1;
      observe();
   endtask

   task automatic checkZeroOutputs(input string tag);
      checkEq({tag, "_busy"}, 32'(busy), 32'd0);
      checkEq({tag, "_done"}, 32'(done), 32'd0);
      checkEq({tag, "_aborted"}, 32'(aborted), 32'd0);
      checkEq({tag, "_rd_en"}, 32'(rd_en), 32'd0);
      checkEq({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      checkEq({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
      checkEq({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      checkEq({tag, "_conv"}, 32'({conv_red, conv_green, conv_blue}), 32'd0);
   endtask

   function automatic logic readyFor(input bit randReady, input int rel, input int lo, input int hi);
      if (randReady) return ($urandom_range(0, 3) != 0);
      return !(rel >= lo && rel <= hi);
   endfunction

   // One frame from start to done, then checked against the frame-level expectations
   task automatic runFrame(input int n, input logic [14:0] numIn, input bit randReady,
                           input int stallLo, input int stallHi, input int restartAt);
      int rel;
      int budget;
      int expDone;
      clearStats();
      num_pixels = numIn;
      budget = 4 * n + 40;
      rel = 0;
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      t0 = cyc;
      while (doneCnt == 0 && rel < budget) begin
         rel++;
         cycle(1'(rel == restartAt), 1'b0, readyFor(randReady, rel, stallLo, stallHi), 1'b0);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      expDone = (n == 0) ? 1 : n + 3 + stallCnt;
      checkEq("done_cnt", 32'(doneCnt), 32'd1);
      checkEq("done_cyc", 32'(doneCyc - t0), 32'(expDone));
      checkEq("wr_cnt", 32'(wrCnt), 32'(n));
      checkEq("rd_cnt", 32'(rdCnt), 32'(n));
      checkEq("busy_cnt", 32'(busyCnt), 32'((n == 0) ? 0 : n + 2 + stallCnt));
      checkEq("abort_cnt", 32'(abortCnt), 32'd0);
      if (n > 0) checkEq("last_addr", 32'(lastWrAddr), 32'(n - 1));
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; abort = 1'b0; wr_ready = 1'b1; num_pixels = '0;
      for (int i = 0; i < 16384; i++) src[i] = 24'($urandom);
      src[0] = 24'hC86432;
      clearStats();

      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      checkZeroOutputs("reset");

      // Basic 4-pixel frame with cycle-exact latency checks
      clearStats();
      num_pixels = 15'd4;
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      t0 = cyc;
      for (int r = 1; r <= 9; r++) begin
         cycle(1'b0, 1'b0, 1'b1, 1'b0);
         if (r == 1) begin
            checkEq("t1_rd_en", 32'(rd_en), 32'd1);
            checkEq("t1_rd_addr", 32'(rd_addr), 32'd0);
            checkEq("t1_busy", 32'(busy), 32'd1);
         end
         if (r == 3) begin
            checkEq("t1_wr_en", 32'(wr_en), 32'd1);
            checkEq("t1_wr_addr", 32'(wr_addr), 32'd0);
            checkEq("t1_conv", 32'({conv_red, conv_green, conv_blue}), 32'h00C86432);
            checkEq("t1_wr_data", 32'(wr_data), 32'(greyOf(24'hC86432)));
         end
      end
      checkEq("t1_done_cyc", 32'(doneCyc - t0), 32'd7);
      checkEq("t1_rd_cnt", 32'(rdCnt), 32'd4);
      checkEq("t1_wr_cnt", 32'(wrCnt), 32'd4);
      checkEq("t1_busy_cnt", 32'(busyCnt), 32'd6);

      // Backpressure at clks 4-6
      runFrame(8, 15'd8, 1'b0, 4, 6, -1);
      checkEq("t2_stall_cnt", 32'(stallCnt), 32'd3);

      // Empty frame
      runFrame(0, 15'd0, 1'b0, -1, -2, -1);

      // Abort at clk 6, restart at clk 9
      clearStats();
      num_pixels = 15'd16;
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      for (int r = 1; r <= 5; r++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      checkEq("t4_wr_en", 32'(wr_en), 32'd0);
      checkEq("t4_busy", 32'(busy), 32'd0);
      checkEq("t4_aborted", 32'(aborted), 32'd1);
      checkEq("t4_rd_en", 32'(rd_en), 32'd0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      checkEq("t4_aborted_pulse", 32'(aborted), 32'd0);
      checkEq("t4_done_cnt", 32'(doneCnt), 32'd0);
      checkEq("t4_wr_cnt", 32'(wrCnt), 32'd4);
      runFrame(5, 15'd5, 1'b0, -1, -2, -1);

      // start re-pulsed mid-frame is ignored
      runFrame(10, 15'd10, 1'b0, -1, -2, 3);

      // Abort and start together while idle: nothing starts
      clearStats();
      num_pixels = 15'd6;
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      for (int r = 0; r < 4; r++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      checkEq("t4b_busy_cnt", 32'(busyCnt), 32'd0);
      checkEq("t4b_done_cnt", 32'(doneCnt), 32'd0);

      // Synchronous reset mid-frame
      clearStats();
      num_pixels = 15'd16;
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      for (int r = 1; r <= 4; r++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      checkZeroOutputs("t6_rst");
      doneCnt = 0; abortCnt = 0;
      for (int r = 0; r < 5; r++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      checkEq("t6_no_done", 32'(doneCnt), 32'd0);
      checkEq("t6_no_abort", 32'(abortCnt), 32'd0);

      // Randomized frames with random backpressure and stray start pulses
      for (int i = 0; i < 10; i++) begin
         n = int'($urandom_range(1, 40));
         runFrame(n, 15'(n), 1'b1, -1, -2, int'($urandom_range(1, 50)));
      end

      // Full frame and an oversized length clamped to a full frame
      runFrame(16384, 15'h4000, 1'b0, -1, -2, -1);
      checkEq("t6_last_addr", 32'(lastWrAddr), 32'h3FFF);
      runFrame(16384, 15'h7FFF, 1'b0, -1, -2, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
